// File: rtl/reg_file_param.sv
// Parametrised multi-read, single-write register file with byte-lane writes,
// optional hardwired-zero entry 0, optional write-through bypass and a sequential clear engine.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_all,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          write_addr,
  input  logic [DATA_W-1:0]          write_data,
  input  logic [DATA_W/8-1:0]        byte_en,
  input  logic [NUM_RD*ADDR_W-1:0]   read_addr,
  output logic [NUM_RD*DATA_W-1:0]   read_data,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       wr_accept
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int NUM_LANES = DATA_W / 8;
  localparam logic ZERO_EN   = (ZERO_REG != 0);
  localparam logic BYPASS_EN = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   clr_ptr_reg;
  logic [ADDR_W-1:0]   clr_ptr_next;
  logic                clr_active;

  logic [DATA_W-1:0]   mem_reg [DEPTH];
  logic [DATA_W-1:0]   merged_data;

  // Clear engine: state register
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      state_reg   <= ST_IDLE;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Clear engine: next state; a request while clearing is deliberately ignored
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    clr_active   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clr_req) begin
          state_next   = ST_CLEAR;
          clr_ptr_next = '0;
        end
      end
      ST_CLEAR: begin
        clr_active   = 1'b1;
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == LAST_IDX) begin
          state_next   = ST_IDLE;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        clr_ptr_next = '0;
      end
    endcase
  end

  assign busy      = (state_reg == ST_CLEAR);
  assign wr_accept = we & ~busy & ~(ZERO_EN & (write_addr == '0));

  // Lane merge of the incoming write with the currently stored entry
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign merged_data[gi*8 +: 8] = byte_en[gi] ? write_data[gi*8 +: 8]
                                                  : mem_reg[write_addr][gi*8 +: 8];
    end
  endgenerate

  // Storage; writes and clearing never coincide since busy blocks wr_accept
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (wr_accept) begin
        mem_reg[write_addr] <= merged_data;
      end
      if (clr_active) begin
        mem_reg[clr_ptr_reg] <= '0;
      end
    end
  end

  // Combinational read ports, each with its own bypass and zero-entry override
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] port_addr;
      logic [DATA_W-1:0] port_data;

      assign port_addr = read_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        port_data = mem_reg[port_addr];
        if (BYPASS_EN && wr_accept && (port_addr == write_addr)) begin
          port_data = merged_data;
        end
        if (ZERO_EN && (port_addr == '0)) begin
          port_data = '0;
        end
      end

      assign read_data[gi*DATA_W +: DATA_W] = port_data;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised self-checking bench for reg_file_param: default build, a no-zero/no-bypass
// build sharing the same stimulus, and a 4-port 64-bit 8-entry build.
module tb_reg_file_param;

  logic         clk;
  logic         rst_all;
  logic         we;
  logic [4:0]   write_addr;
  logic [31:0]  write_data;
  logic [3:0]   byte_en;
  logic [9:0]   read_addr;
  logic         clr_req;
  logic [63:0]  rd0;
  logic [63:0]  rd1;
  logic         busy0, busy1, acc0, acc1;

  logic         we_w;
  logic [2:0]   waddr_w;
  logic [63:0]  wdata_w;
  logic [7:0]   be_w;
  logic [11:0]  raddr_w;
  logic         clr_w;
  logic [255:0] rd_w;
  logic         busy_w, acc_w;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [63:0] mw [8];
  logic        m_busy;
  int          m_idx;
  logic        mw_busy;
  int          mw_idx;

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .rst_all(rst_all), .we(we), .write_addr(write_addr), .write_data(write_data),
    .byte_en(byte_en), .read_addr(read_addr), .read_data(rd0), .clr_req(clr_req),
    .busy(busy0), .wr_accept(acc0)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst_all(rst_all), .we(we), .write_addr(write_addr), .write_data(write_data),
    .byte_en(byte_en), .read_addr(read_addr), .read_data(rd1), .clr_req(clr_req),
    .busy(busy1), .wr_accept(acc1)
  );

  reg_file_param #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(1)) dut_w (
    .clk(clk), .rst_all(rst_all), .we(we_w), .write_addr(waddr_w), .write_data(wdata_w),
    .byte_en(be_w), .read_addr(raddr_w), .read_data(rd_w), .clr_req(clr_w),
    .busy(busy_w), .wr_accept(acc_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] merge(input logic [63:0] nw, input logic [7:0] be,
                                        input logic [63:0] old);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k*8 +: 8] = be[k] ? nw[k*8 +: 8] : old[k*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic exp_acc(input int inst);
    return we && !m_busy && !(inst == 0 && write_addr == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] a);
    logic [63:0] t;
    if (inst == 0) begin
      if (a == 5'd0) return 32'h0;
      if (exp_acc(0) && a == write_addr) begin
        t = merge({32'h0, write_data}, {4'h0, byte_en}, {32'h0, m0[a]});
        return t[31:0];
      end
      return m0[a];
    end
    return m1[a];
  endfunction

  function automatic logic exp_acc_w();
    return we_w && !mw_busy;
  endfunction

  function automatic logic [63:0] exp_rd_w(input logic [2:0] a);
    if (exp_acc_w() && a == waddr_w) return merge(wdata_w, be_w, mw[a]);
    return mw[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m0[i] = 32'h0;
      m1[i] = 32'h0;
    end
    for (int i = 0; i < 8; i++) mw[i] = 64'h0;
    m_busy  = 1'b0;
    m_idx   = 0;
    mw_busy = 1'b0;
    mw_idx  = 0;
  endtask

  // Apply the behaviour of one rising edge to the reference state
  task automatic model_edge();
    logic        a0, a1, aw;
    logic [63:0] t;
    if (!rst_all) return;
    a0 = exp_acc(0);
    a1 = exp_acc(1);
    aw = exp_acc_w();
    if (a0) begin
      t = merge({32'h0, write_data}, {4'h0, byte_en}, {32'h0, m0[write_addr]});
      m0[write_addr] = t[31:0];
    end
    if (a1) begin
      t = merge({32'h0, write_data}, {4'h0, byte_en}, {32'h0, m1[write_addr]});
      m1[write_addr] = t[31:0];
    end
    if (m_busy) begin
      m0[m_idx] = 32'h0;
      m1[m_idx] = 32'h0;
      m_idx++;
      if (m_idx == 32) m_busy = 1'b0;
    end else if (clr_req) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end
    if (aw) mw[waddr_w] = merge(wdata_w, be_w, mw[waddr_w]);
    if (mw_busy) begin
      mw[mw_idx] = 64'h0;
      mw_idx++;
      if (mw_idx == 8) mw_busy = 1'b0;
    end else if (clr_w) begin
      mw_busy = 1'b1;
      mw_idx  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; write_addr = '0; write_data = '0; byte_en = '0; read_addr = '0; clr_req = 1'b0;
    we_w = 1'b0; waddr_w = '0; wdata_w = '0; be_w = '0; raddr_w = '0; clr_w = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_all = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || busy_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b%b%b exp=000", busy0, busy1, busy_w);
    end
    for (int i = 0; i < 8; i++) begin
      read_addr = 10'($urandom);
      raddr_w   = 12'($urandom);
      #1;
      checks++;
      if (rd0 !== 64'h0 || rd1 !== 64'h0 || rd_w !== 256'h0) begin
        errors++;
        $display("FAIL reset_read got=%h/%h exp=0", rd0, rd1);
      end
    end
    rst_all = 1'b1;
    tick();
  endtask

  task automatic test_write_basic();
    we = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF; byte_en = 4'hF;
    tick();
    we = 1'b0;
    read_addr = {5'd5, 5'd5};
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rd0[p*32 +: 32] !== 32'hDEADBEEF || rd1[p*32 +: 32] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL write_basic port%0d got=%h/%h exp=deadbeef", p, rd0[p*32 +: 32], rd1[p*32 +: 32]);
      end
    end
    tick();
  endtask

  task automatic test_byte_lanes();
    we = 1'b1; write_addr = 5'd7; write_data = 32'h11223344; byte_en = 4'hF;
    tick();
    write_data = 32'hAABBCCDD; byte_en = 4'b0101;
    read_addr = {5'd7, 5'd7};
    @(negedge clk);
    checks++;
    if (rd0[31:0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL bypass_on got=%h exp=11bb33dd", rd0[31:0]);
    end
    checks++;
    if (rd1[31:0] !== 32'h11223344) begin
      errors++;
      $display("FAIL bypass_off got=%h exp=11223344", rd1[31:0]);
    end
    tick();
    we = 1'b0;
    @(negedge clk);
    checks++;
    if (rd0[63:32] !== 32'h11BB33DD || rd1[63:32] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL lane_merge got=%h/%h exp=11bb33dd", rd0[63:32], rd1[63:32]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF; byte_en = 4'hF;
    read_addr = {5'd0, 5'd0};
    @(negedge clk);
    checks++;
    if (acc0 !== 1'b0 || acc1 !== 1'b1) begin
      errors++;
      $display("FAIL zero_accept got=%b%b exp=01", acc0, acc1);
    end
    checks++;
    if (rd0[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL zero_read_wcycle got=%h exp=0", rd0[31:0]);
    end
    tick();
    we = 1'b0;
    @(negedge clk);
    checks++;
    if (rd0[31:0] !== 32'h0 || rd1[31:0] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL zero_read got=%h/%h exp=0/ffffffff", rd0[31:0], rd1[31:0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      we = ($urandom % 4) != 0;
      write_addr = 5'($urandom);
      write_data = $urandom;
      byte_en = 4'($urandom);
      read_addr = 10'($urandom);
      if ($urandom % 3 == 0) read_addr[4:0] = write_addr;
      if ($urandom % 3 == 0) read_addr[9:5] = write_addr;
      @(negedge clk);
      checks++;
      if (acc0 !== exp_acc(0) || acc1 !== exp_acc(1)) begin
        errors++;
        $display("FAIL rand_accept c=%0d got=%b%b exp=%b%b", c, acc0, acc1, exp_acc(0), exp_acc(1));
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd0[p*32 +: 32] !== exp_rd(0, read_addr[p*5 +: 5]) ||
            rd1[p*32 +: 32] !== exp_rd(1, read_addr[p*5 +: 5])) begin
          errors++;
          $display("FAIL rand_read c=%0d port%0d addr=%0d got=%h/%h exp=%h/%h", c, p,
                   read_addr[p*5 +: 5], rd0[p*32 +: 32], rd1[p*32 +: 32],
                   exp_rd(0, read_addr[p*5 +: 5]), exp_rd(1, read_addr[p*5 +: 5]));
        end
      end
      tick();
    end
    we = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; write_addr = 5'(i); write_data = i * 32'h01010101; byte_en = 4'hF;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_clear();
    fill_pattern();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      we = (c <= 32) && ($urandom % 2 == 1);
      write_addr = 5'($urandom);
      write_data = $urandom;
      byte_en = 4'hF;
      clr_req = (c == 10);
      read_addr = {5'(c - 1), 5'((c >= 2) ? c - 2 : 0)};
      @(negedge clk);
      checks++;
      if (busy0 !== (c <= 32) || busy1 !== (c <= 32)) begin
        errors++;
        $display("FAIL clear_busy c=%0d got=%b%b exp=%b", c, busy0, busy1, c <= 32);
      end
      if (c <= 32) begin
        checks++;
        if (acc0 !== 1'b0 || acc1 !== 1'b0) begin
          errors++;
          $display("FAIL clear_accept c=%0d got=%b%b exp=00", c, acc0, acc1);
        end
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd0[p*32 +: 32] !== exp_rd(0, read_addr[p*5 +: 5]) ||
            rd1[p*32 +: 32] !== exp_rd(1, read_addr[p*5 +: 5])) begin
          errors++;
          $display("FAIL clear_read c=%0d port%0d got=%h/%h exp=%h/%h", c, p,
                   rd0[p*32 +: 32], rd1[p*32 +: 32],
                   exp_rd(0, read_addr[p*5 +: 5]), exp_rd(1, read_addr[p*5 +: 5]));
        end
      end
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 32; i += 2) begin
      read_addr = {5'(i + 1), 5'(i)};
      #1;
      checks++;
      if (rd0[63:0] !== 64'h0 || rd1[63:0] !== 64'h0) begin
        errors++;
        $display("FAIL post_clear entries %0d,%0d got=%h/%h exp=0", i, i + 1, rd0, rd1);
      end
    end
    tick();
  endtask

  task automatic test_clear_abort();
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; write_addr = 5'(i); write_data = $urandom | 32'h1; byte_en = 4'hF;
      tick();
    end
    we = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    rst_all = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got=%b%b exp=00", busy0, busy1);
    end
    for (int i = 0; i < 32; i += 2) begin
      read_addr = {5'(i + 1), 5'(i)};
      #1;
      checks++;
      if (rd0[63:0] !== 64'h0 || rd1[63:0] !== 64'h0) begin
        errors++;
        $display("FAIL abort_read entries %0d,%0d got=%h/%h exp=0", i, i + 1, rd0, rd1);
      end
    end
    @(negedge clk);
    rst_all = 1'b1;
    tick();
  endtask

  task automatic test_wide();
    for (int i = 0; i < 8; i++) begin
      we_w = 1'b1; waddr_w = 3'(i); wdata_w = {$urandom, $urandom}; be_w = 8'hFF;
      tick();
    end
    we_w = 1'b0;
    for (int c = 0; c < 40; c++) begin
      int s;
      s = int'($urandom % 8);
      raddr_w = {3'(s + 3), 3'(s + 2), 3'(s + 1), 3'(s)};
      if (c >= 4) begin
        we_w = ($urandom % 2) == 1;
        waddr_w = 3'($urandom);
        wdata_w = {$urandom, $urandom};
        be_w = 8'($urandom);
      end
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rd_w[p*64 +: 64] !== exp_rd_w(raddr_w[p*3 +: 3])) begin
          errors++;
          $display("FAIL wide_read c=%0d port%0d addr=%0d got=%h exp=%h", c, p,
                   raddr_w[p*3 +: 3], rd_w[p*64 +: 64], exp_rd_w(raddr_w[p*3 +: 3]));
        end
      end
      tick();
    end
    we_w = 1'b0;
    clr_w = 1'b1;
    tick();
    clr_w = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (busy_w !== (c <= 8)) begin
        errors++;
        $display("FAIL wide_busy c=%0d got=%b exp=%b", c, busy_w, c <= 8);
      end
      tick();
    end
    for (int i = 0; i < 8; i += 4) begin
      raddr_w = {3'(i + 3), 3'(i + 2), 3'(i + 1), 3'(i)};
      #1;
      checks++;
      if (rd_w !== 256'h0) begin
        errors++;
        $display("FAIL wide_post_clear base=%0d got=%h exp=0", i, rd_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_byte_lanes();
    test_zero_reg();
    test_random();
    test_clear();
    test_clear_abort();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
